stream_mux_arb: RTL and testbench

//  N-channel stream multiplexer, parametrised successor to the 2:1 combinational mux.

---
 rtl/stream_mux_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/stream_mux_arb.sv | 144 ++++++++++++++
 tb/tb_stream_mux_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
//   Shared types and helpers for the stream_mux_arb block.
//   - arb_state_e   : arbiter FSM state (IDLE = free to arbitrate,
//                     LOCKED = grant pinned to one channel until end-of-packet)
//   - MAX_CH        : widest request vector onehot_to_idx can encode
//   - onehot_to_idx : one-hot (or zero) vector -> binary index
// ---------------------------------------------------------------------------
package stream_mux_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_CH = 64;

  // ORing the positions of all set bits yields the index when at most one bit
  // is set, and needs no priority chain.
  function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational arbiter, round-robin (RR_MODE=1) or fixed lowest-index
//   priority (RR_MODE=0).
//   Ports:
//     req     in  [NUM_CH]  request vector
//     ptr     in  [SEL_W]   highest-priority channel in round-robin mode
//     gnt     out [NUM_CH]  one-hot grant, zero when no request
//     gnt_idx out [SEL_W]   binary index of gnt
//     gnt_any out           at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  bit RR_MODE = 1'b1,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [2*NUM_CH-1:0] w_dbl_req;
  logic [2*NUM_CH-1:0] w_mask;
  logic [2*NUM_CH-1:0] w_hit;

  // The request vector is duplicated and the lower copy masked below ptr, so
  // the lowest surviving bit is the first requester at or after ptr with the
  // wrap-around handled by the upper copy.
  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_dbl_req = {req, req};
    w_mask    = '1;
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      if (RR_MODE) w_mask[i] = (i >= int'(ptr));
    end
    w_hit = w_dbl_req & w_mask;
    gnt   = '0;
    // Scan downwards so the lowest hit is the last one written.
    for (int i = 2 * NUM_CH - 1; i >= 0; i--) begin
      if (w_hit[i]) gnt = NUM_CH'(1) << (i % NUM_CH);
    end
  end

  assign gnt_any = |req;
  assign gnt_idx = SEL_W'(onehot_to_idx(MAX_CH'(gnt)));

endmodule

// File: rtl/stream_mux_arb.sv
// ---------------------------------------------------------------------------
// stream_mux_arb
//   NUM_CH-to-1 valid/ready stream multiplexer with internal arbitration,
//   optional packet locking and a registered output stage.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     in_valid    [NUM_CH]         per-channel valid
//     in_ready    [NUM_CH]         per-channel ready, at most one bit high
//     in_data     [NUM_CH*DATA_W]  channel i payload at [i*DATA_W +: DATA_W]
//     in_last     [NUM_CH]         per-channel end-of-packet
//     out_valid/out_ready/out_data/out_last  registered output stream
//     out_sel     [SEL_W]          channel that sourced the current beat
// ---------------------------------------------------------------------------
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int DATA_W       = 8,
  parameter  bit RR_MODE      = 1'b1,
  parameter  bit LOCK_ON_LAST = 1'b1,
  localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [SEL_W-1:0]    r_lock_ch;
  logic [SEL_W-1:0]    r_ptr;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic [SEL_W-1:0]    r_out_sel;

  logic [NUM_CH-1:0]   w_arb_gnt;
  logic [SEL_W-1:0]    w_arb_idx;
  logic                w_arb_any;
  logic [NUM_CH-1:0]   w_gnt;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic                w_take;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_ch_data [NUM_CH];
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_last;
  logic [SEL_W-1:0]    w_ptr_inc;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .gnt_any (w_arb_any)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_split
    assign w_ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  // The output register can take a beat when empty or being drained.
  assign w_take     = ~r_out_valid | out_ready;
  // in_ready is forced low during reset so nothing is taken while the
  // registers are being cleared.
  assign in_ready   = rst_n ? (w_gnt & {NUM_CH{w_take}}) : '0;
  assign w_xfer     = |(in_valid & in_ready);
  assign w_sel_data = w_ch_data[w_gnt_idx];
  assign w_sel_last = in_last[w_gnt_idx];
  assign w_ptr_inc  = (w_gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. The lock is only ever entered when LOCK_ON_LAST is set.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE:   if (LOCK_ON_LAST && w_xfer && !w_sel_last) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (w_xfer && w_sel_last)                  w_state_nxt = ARB_IDLE;
      default:                                               w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant output: while locked the grant stays on lock_ch even if that channel
  // is idle, which produces bubbles instead of letting another channel in.
  always_comb begin
    w_gnt     = w_arb_any ? w_arb_gnt : '0;
    w_gnt_idx = w_arb_idx;
    if (r_state == ARB_LOCKED) begin
      w_gnt     = NUM_CH'(1) << r_lock_ch;
      w_gnt_idx = r_lock_ch;
    end
  end

  // Lock channel and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_ch <= '0;
      r_ptr     <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_state_nxt == ARB_LOCKED) r_lock_ch <= w_gnt_idx;
      if (w_xfer && (w_sel_last || !LOCK_ON_LAST))          r_ptr     <= w_ptr_inc;
    end
  end

  // Output register: load on accept, otherwise drain when the consumer takes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_sel   <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_arb
//   Directed bench for stream_mux_arb. Two instances share clock and reset:
//   dut (round-robin, packet lock) and fp (fixed priority, packet lock).
// ---------------------------------------------------------------------------
module tb_stream_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  logic [3:0]  fp_in_valid, fp_in_ready, fp_in_last;
  logic [31:0] fp_in_data;
  logic        fp_out_valid, fp_out_ready, fp_out_last;
  logic [7:0]  fp_out_data;
  logic [1:0]  fp_out_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .RR_MODE(1'b1), .LOCK_ON_LAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel)
  );

  stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .RR_MODE(1'b0), .LOCK_ON_LAST(1'b1)) fp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(fp_in_valid), .in_ready(fp_in_ready), .in_data(fp_in_data), .in_last(fp_in_last),
    .out_valid(fp_out_valid), .out_ready(fp_out_ready), .out_data(fp_out_data),
    .out_last(fp_out_last), .out_sel(fp_out_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic [1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".last"},  32'(out_last),  32'(l));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
    in_valid[ch]       = v;
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 4'hF;
    in_data      = '0;
    in_last      = '0;
    out_ready    = 1'b1;
    fp_in_valid  = 4'hF;
    fp_in_data   = '0;
    fp_in_last   = '0;
    fp_out_ready = 1'b1;

    // Reset state, with every channel requesting.
    tick();
    tick();
    check_out("reset", 1'b0, 8'h00, 1'b0, 2'd0);
    check("reset.in_ready", 32'(in_ready), 32'h0);
    check("reset.fp_in_ready", 32'(fp_in_ready), 32'h0);

    // Round-robin fairness and fixed priority run side by side.
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 1'b1);
    fp_in_valid       = 4'b0101;
    fp_in_data[7:0]   = 8'h50;
    fp_in_data[23:16] = 8'h52;
    fp_in_last        = 4'hF;
    rst_n = 1'b1;
    #1;
    check("rr.gnt0", 32'(in_ready), 32'h1);
    check("fp.gnt0", 32'(fp_in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("rr", 1'b1, 8'(8'h10 + (k % 4)), 1'b1, 2'(k % 4));
      check("rr.in_ready", 32'(in_ready), 32'(1 << ((k + 1) % 4)));
      check("fp.valid", 32'(fp_out_valid), 32'h1);
      check("fp.data",  32'(fp_out_data),  32'h50);
      check("fp.sel",   32'(fp_out_sel),   32'h0);
      check("fp.in_ready", 32'(fp_in_ready), 32'h1);
    end
    fp_in_valid = 4'h0;
    in_valid    = 4'h0;
    tick();
    tick();
    check("drain.valid", 32'(out_valid), 32'h0);

    // Backpressure: hold 0xA5 for 5 cycles with the next beat waiting.
    set_ch(1, 1'b1, 8'hA5, 1'b1);
    out_ready = 1'b0;
    #1;
    check("bp.gnt", 32'(in_ready), 32'h2);
    tick();
    check_out("bp.load", 1'b1, 8'hA5, 1'b1, 2'd1);
    set_ch(1, 1'b1, 8'hB6, 1'b1);
    #1;
    for (int c = 0; c < 5; c++) begin
      check_out("bp.hold", 1'b1, 8'hA5, 1'b1, 2'd1);
      check("bp.in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release", 32'(in_ready), 32'h2);
    tick();
    check_out("bp.next", 1'b1, 8'hB6, 1'b1, 2'd1);
    in_valid = 4'h0;
    tick();
    check("bp.empty", 32'(out_valid), 32'h0);

    // Reset mid-packet while out_valid=1; lock must be dropped.
    set_ch(2, 1'b1, 8'h31, 1'b0);
    #1;
    check("rst.pre_gnt", 32'(in_ready), 32'h4);
    tick();
    check_out("rst.pre", 1'b1, 8'h31, 1'b0, 2'd2);
    set_ch(2, 1'b1, 8'h32, 1'b0);
    set_ch(3, 1'b1, 8'h3F, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h40 + i), 1'b1);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst.first_gnt", 32'(in_ready), 32'h1);
    tick();
    check_out("rst.first", 1'b1, 8'h40, 1'b1, 2'd0);
    in_valid = 4'h0;
    tick();
    check("rst.empty", 32'(out_valid), 32'h0);

    // Packet lock: ch1 three beats, ch0 arrives one cycle later.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ch(1, 1'b1, 8'h21, 1'b0);
    #1;
    check("pkt.gnt1", 32'(in_ready), 32'h2);
    tick();
    check_out("pkt.b1", 1'b1, 8'h21, 1'b0, 2'd1);
    set_ch(1, 1'b1, 8'h22, 1'b0);
    set_ch(0, 1'b1, 8'h01, 1'b1);
    #1;
    check("pkt.gnt2", 32'(in_ready), 32'h2);
    tick();
    check_out("pkt.b2", 1'b1, 8'h22, 1'b0, 2'd1);
    set_ch(1, 1'b1, 8'h23, 1'b1);
    #1;
    check("pkt.gnt3", 32'(in_ready), 32'h2);
    tick();
    check_out("pkt.b3", 1'b1, 8'h23, 1'b1, 2'd1);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    #1;
    check("pkt.gnt_ch0", 32'(in_ready), 32'h1);
    tick();
    check_out("pkt.ch0", 1'b1, 8'h01, 1'b1, 2'd0);
    in_valid = 4'h0;
    tick();
    check("pkt.empty", 32'(out_valid), 32'h0);

    // Locked bubble: ch2 pauses 2 cycles mid-packet while ch3 waits.
    set_ch(2, 1'b1, 8'h61, 1'b0);
    #1;
    check("bub.gnt", 32'(in_ready), 32'h4);
    tick();
    check_out("bub.b1", 1'b1, 8'h61, 1'b0, 2'd2);
    set_ch(2, 1'b0, 8'h00, 1'b0);
    set_ch(3, 1'b1, 8'h7F, 1'b1);
    #1;
    check("bub.hold1", 32'(in_ready), 32'h4);
    tick();
    check("bub.gap1", 32'(out_valid), 32'h0);
    check("bub.hold2", 32'(in_ready), 32'h4);
    tick();
    check("bub.gap2", 32'(out_valid), 32'h0);
    set_ch(2, 1'b1, 8'h62, 1'b1);
    #1;
    check("bub.resume", 32'(in_ready), 32'h4);
    tick();
    check_out("bub.b2", 1'b1, 8'h62, 1'b1, 2'd2);
    set_ch(2, 1'b0, 8'h00, 1'b0);
    #1;
    check("bub.gnt_ch3", 32'(in_ready), 32'h8);
    tick();
    check_out("bub.ch3", 1'b1, 8'h7F, 1'b1, 2'd3);
    in_valid = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
